// File: rtl/float_pkg.sv
// Shared constants for the byte-serial float classifier: one-hot class codes,
// exponent helpers and the FSM state encoding.
package float_pkg;

   localparam int NUM_CLASSES = 5;

   localparam logic [4:0] CLS_ZERO      = 5'b00001;
   localparam logic [4:0] CLS_NORMAL    = 5'b00010;
   localparam logic [4:0] CLS_SUBNORMAL = 5'b00100;
   localparam logic [4:0] CLS_INFINITY  = 5'b01000;
   localparam logic [4:0] CLS_NAN       = 5'b10000;

   localparam logic [7:0] EXP_ALL_ONES = 8'hFF;

   typedef enum logic {
      COLLECT = 1'b0,
      HOLD    = 1'b1
   } state_t;

endpackage

// File: rtl/float_classify.sv
// Combinational IEEE-754 single classifier; the sign bit plays no part.
module float_classify
   import float_pkg::*;
(
   input  logic [31:0] num,
   output logic [4:0]  num_class
);

   logic [7:0]  exp_f;
   logic [22:0] frac_f;

   assign exp_f  = num[30:23];
   assign frac_f = num[22:0];

   always_comb begin
      num_class = CLS_NAN;
      if (exp_f == 8'h00) begin
         num_class = (frac_f == 23'd0) ? CLS_ZERO : CLS_SUBNORMAL;
      end else if (exp_f != EXP_ALL_ONES) begin
         num_class = CLS_NORMAL;
      end else if (frac_f == 23'd0) begin
         num_class = CLS_INFINITY;
      end
   end

endmodule

// File: rtl/float_stream_classifier.sv
// Assembles MSB-first bytes into a float, holds it for a ready/valid consumer,
// and keeps a saturating per-class count of words handed off.
//
// state   | meaning
// COLLECT | accepting bytes into the word, index selects the byte lane
// HOLD    | full word presented on out_*, waiting for out_ready
module float_stream_classifier
   import float_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [7:0]       in_byte,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_num,
   output logic [4:0]       out_type,
   input  logic             clr,
   input  logic [2:0]       cnt_sel,
   output logic [CNT_W-1:0] cnt_val
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t           state;
   logic [1:0]       idx;
   logic [CNT_W-1:0] cnt [NUM_CLASSES];
   logic             handshake;

   assign handshake = out_valid && out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= COLLECT;
         idx       <= 2'd0;
         out_num   <= 32'd0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         case (state)
            COLLECT: begin
               if (in_valid) begin
                  case (idx)
                     2'd0:    out_num[31:24] <= in_byte;
                     2'd1:    out_num[23:16] <= in_byte;
                     2'd2:    out_num[15:8]  <= in_byte;
                     default: out_num[7:0]   <= in_byte;
                  endcase
                  idx <= idx + 2'd1;
                  if (idx == 2'd3) begin
                     state     <= HOLD;
                     in_ready  <= 1'b0;
                     out_valid <= 1'b1;
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state     <= COLLECT;
                  in_ready  <= 1'b1;
                  out_valid <= 1'b0;
               end
            end
            default: begin
               state     <= COLLECT;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

   float_classify u_classify (
      .num       (out_num),
      .num_class (out_type)
   );

   // clr takes priority over a same-cycle handshake
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CLASSES; i++) cnt[i] <= '0;
      end else if (clr) begin
         for (int i = 0; i < NUM_CLASSES; i++) cnt[i] <= '0;
      end else if (handshake) begin
         for (int i = 0; i < NUM_CLASSES; i++) begin
            if (out_type[i] && (cnt[i] != CNT_MAX)) cnt[i] <= cnt[i] + 1'b1;
         end
      end
   end

   always_comb begin
      cnt_val = '0;
      case (cnt_sel)
         3'd0:    cnt_val = cnt[0];
         3'd1:    cnt_val = cnt[1];
         3'd2:    cnt_val = cnt[2];
         3'd3:    cnt_val = cnt[3];
         3'd4:    cnt_val = cnt[4];
         default: cnt_val = '0;
      endcase
   end

endmodule

// File: tb/tb_float_stream_classifier.sv
// Directed bench: a default-width and a 4-bit-counter instance share stimulus;
// expected values are hand-computed constants.
module tb_float_stream_classifier;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [7:0]  in_byte;
   logic        out_ready;
   logic        clr;
   logic [2:0]  cnt_sel;

   logic        in_ready,  in_ready4;
   logic        out_valid, out_valid4;
   logic [31:0] out_num,   out_num4;
   logic [4:0]  out_type,  out_type4;
   logic [15:0] cnt_val;
   logic [3:0]  cnt_val4;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   float_stream_classifier dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_byte(in_byte),
      .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
      .out_num(out_num), .out_type(out_type), .clr(clr),
      .cnt_sel(cnt_sel), .cnt_val(cnt_val)
   );

   float_stream_classifier #(.CNT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_byte(in_byte),
      .in_ready(in_ready4), .out_valid(out_valid4), .out_ready(out_ready),
      .out_num(out_num4), .out_type(out_type4), .clr(clr),
      .cnt_sel(cnt_sel), .cnt_val(cnt_val4)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      in_valid = 1'b1;
      in_byte  = b;
      step();
      in_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      send_byte(w[31:24]);
      send_byte(w[23:16]);
      send_byte(w[15:8]);
      send_byte(w[7:0]);
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   task automatic check_cnt(input string tag, input logic [2:0] sel, input logic [31:0] exp);
      cnt_sel = sel;
      #1;
      check(tag, {16'd0, cnt_val}, exp);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_byte = 8'h00;
      out_ready = 1'b0; clr = 1'b0; cnt_sel = 3'd0;
      step(); step();

      // reset state
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_in_ready",  {31'd0, in_ready},  32'd1);
      check("rst_out_num",   out_num, 32'h0);
      check("rst_out_type",  {27'd0, out_type}, 32'h01);
      check_cnt("rst_cnt0", 3'd0, 32'd0);
      rst_n = 1'b1;
      step();

      // 1.0: out_valid appears only after the fourth byte
      send_byte(8'h3F); send_byte(8'h80); send_byte(8'h00);
      check("one_not_valid_3b", {31'd0, out_valid}, 32'd0);
      send_byte(8'h00);
      check("one_valid",    {31'd0, out_valid}, 32'd1);
      check("one_in_ready", {31'd0, in_ready},  32'd0);
      check("one_num",      out_num, 32'h3F800000);
      check("one_type",     {27'd0, out_type}, 32'h02);
      handshake();
      check("one_after_hs_valid", {31'd0, out_valid}, 32'd0);
      check_cnt("one_cnt1", 3'd1, 32'd1);

      // one word of each remaining class
      send_word(32'h80000000);
      check("negzero_type", {27'd0, out_type}, 32'h01);
      handshake();
      send_word(32'h00000001);
      check("subnorm_type", {27'd0, out_type}, 32'h04);
      handshake();
      send_word(32'h7F800000);
      check("inf_type", {27'd0, out_type}, 32'h08);
      handshake();
      send_word(32'h7FC00000);
      check("nan_type", {27'd0, out_type}, 32'h10);
      handshake();
      check_cnt("cls_cnt0", 3'd0, 32'd1);
      check_cnt("cls_cnt1", 3'd1, 32'd1);
      check_cnt("cls_cnt2", 3'd2, 32'd1);
      check_cnt("cls_cnt3", 3'd3, 32'd1);
      check_cnt("cls_cnt4", 3'd4, 32'd1);
      check_cnt("sel5_zero", 3'd5, 32'd0);
      check_cnt("sel7_zero", 3'd7, 32'd0);

      // backpressure in HOLD with upstream still offering bytes
      send_word(32'h40490FDB);
      cnt_sel = 3'd1;
      in_valid = 1'b1; in_byte = 8'hAA;
      for (int i = 0; i < 3; i++) begin
         step();
         check("bp_in_ready", {31'd0, in_ready}, 32'd0);
         check("bp_num",      out_num, 32'h40490FDB);
         check("bp_cnt1",     {16'd0, cnt_val}, 32'd1);
      end
      handshake();
      in_valid = 1'b0;
      check_cnt("bp_cnt1_after", 3'd1, 32'd2);
      send_word(32'hC0000000);
      check("bp_next_num",  out_num, 32'hC0000000);
      check("bp_next_type", {27'd0, out_type}, 32'h02);
      handshake();
      check_cnt("bp_next_cnt1", 3'd1, 32'd3);

      // reset mid-word discards the partial word
      send_byte(8'h12); send_byte(8'h34);
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
      check("mid_rst_num",   out_num, 32'h0);
      step();
      rst_n = 1'b1;
      step();
      send_byte(8'h7F); send_byte(8'h80); send_byte(8'h00);
      check("mid_rst_not_valid", {31'd0, out_valid}, 32'd0);
      send_byte(8'h01);
      check("mid_rst_num_new",  out_num, 32'h7F800001);
      check("mid_rst_type_new", {27'd0, out_type}, 32'h10);
      handshake();
      check_cnt("mid_rst_cnt4", 3'd4, 32'd1);

      // clr wins over a same-cycle handshake
      send_word(32'h3F800000);
      handshake();
      check_cnt("clr_pre_cnt1", 3'd1, 32'd1);
      send_word(32'h3F800000);
      clr = 1'b1;
      handshake();
      clr = 1'b0;
      check_cnt("clr_hs_cnt1", 3'd1, 32'd0);
      check_cnt("clr_hs_cnt4", 3'd4, 32'd0);
      check("clr_hs_valid", {31'd0, out_valid}, 32'd0);

      // saturation of the 4-bit counters
      for (int i = 0; i < 17; i++) begin
         send_word(32'h00000000);
         handshake();
         if (i == 14) begin
            cnt_sel = 3'd0;
            #1;
            check("sat_cnt4_at15", {28'd0, cnt_val4}, 32'd15);
         end
      end
      cnt_sel = 3'd0;
      #1;
      check("sat_cnt4_after17", {28'd0, cnt_val4}, 32'd15);
      check("sat_cnt16_after17", {16'd0, cnt_val}, 32'd17);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/float_stream_classifier.md
FLOAT_STREAM_CLASSIFIER -- requirements
Module: float_stream_classifier

Interface
REQ-001 Parameter: CNT_W, default 16, width of each per-class event counter.
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: in_valid  input  1  in_byte holds a valid byte.
REQ-005 Port: in_byte  input  8  byte-serial IEEE-754 single, MSB byte first.
REQ-006 Port: in_ready  output  1  block accepts a byte this cycle.
REQ-007 Port: out_valid  output  1  assembled word and class are valid.
REQ-008 Port: out_ready  input  1  consumer accepts the output.
REQ-009 Port: out_num  output  32  assembled word.
REQ-010 Port: out_type  output  5  one-hot class: bit0 zero, bit1 normal, bit2 subnormal, bit3 infinity, bit4 NaN.
REQ-011 Port: clr  input  1  synchronous clear of all counters.
REQ-012 Port: cnt_sel  input  3  counter select; 0..4 map to the out_type bit index.
REQ-013 Port: cnt_val  output  CNT_W  selected counter value, combinational from cnt_sel.

Function
REQ-014 FSM shall have two states: COLLECT and HOLD.
REQ-015 In COLLECT, in_ready shall be 1; in HOLD, in_ready shall be 0.
REQ-016 A byte is accepted on a cycle with in_valid and in_ready both 1; a 2-bit index shall select bits 31:24, 23:16, 15:8, 7:0 in order.
REQ-017 On acceptance of the fourth byte, the FSM shall enter HOLD and the index shall wrap to 0.
REQ-018 out_valid shall be 1 exactly when in HOLD, i.e. from the cycle after the fourth byte is accepted.
REQ-019 Class rules: exp==0 and frac==0 gives zero; exp==0 and frac!=0 gives subnormal; exp neither 0 nor 0xFF gives normal; exp==0xFF and frac==0 gives infinity; otherwise NaN. The sign bit shall be ignored.
REQ-020 out_num and out_type shall stay stable while out_valid=1 and out_ready=0.
REQ-021 On the cycle with out_valid=1 and out_ready=1, the FSM shall return to COLLECT, and the counter for the class shall increment by 1.
REQ-022 Counters shall saturate at 2^CNT_W-1.
REQ-023 clr shall zero all counters next edge; when clr and a handshake occur in the same cycle, clr shall win and the counter shall read 0.
REQ-024 cnt_sel values 5..7 shall return 0.
REQ-025 in_valid bytes presented while in_ready=0 shall be ignored; the upstream must hold them.

Reset
REQ-026 On rst_n low: state COLLECT, byte index 0, out_num 0, out_valid 0, all counters 0; out_type shall show zero-class (5'b00001) for out_num 0.
REQ-027 A reset asserted mid-word or in HOLD shall discard the partial or held word without any counter update.

Structure
REQ-028 Shared package float_pkg shall hold the one-hot class constants, EXP_ALL_ONES (8'hFF), and the state encoding.
REQ-029 Classification shall be a combinational sub-module float_classify (num[31:0] to type[4:0]), instantiated on the assembled register.

Verification
REQ-030 Bytes 3F 80 00 00 -> out_num 0x3F800000, out_type 5'b00010, out_valid on the cycle after byte 4; after the handshake, cnt_sel=1 gives 1.
REQ-031 Words 0x80000000, 0x00000001, 0x7F800000, 0x7FC00000 -> out_type 00001, 00100, 01000, 10000; counters 0, 2, 3, 4 each equal 1.
REQ-032 out_ready held 0 for 3 cycles in HOLD with in_valid=1 -> in_ready 0, out_num unchanged, no byte consumed, counter unchanged until the handshake.
REQ-033 rst_n pulsed low after 2 bytes -> index 0, out_valid 0; the next 4 bytes form a complete new word.
REQ-034 With CNT_W=4, 17 zero words -> cnt_val (sel 0) stays at 4'hF.
REQ-035 clr asserted on a handshake cycle of a normal word -> cnt_val for sel 1 reads 0 the next cycle.
